branch_resolve_ctrl: RTL and testbench

//   Sequences the RV32I branch comparator for the EX stage. Accepts one conditional branch at a time over a valid/ready

---
 rtl/branch_resolve_ctrl_if.sv | 68 ++++++
 rtl/branch_resolve_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl_if
//   Bundles every non-clock/reset signal of branch_resolve_ctrl.
//
//   master : the EX/fetch side driving branch requests, lookup PCs and
//            accepting redirects.
//   slave  : the branch_resolve_ctrl block itself.
//
//   Handshake rules (both req_* and redirect_*):
//     A transfer happens on a rising clk edge where valid && ready are both 1.
//     Once valid is raised, the sender holds valid and its payload stable
//     until that transfer edge. Ready may change freely and never depends
//     combinationally on valid.
//
//   Signals:
//     req_valid/req_ready        branch request handshake
//     req_funct3                 RV32I branch funct3
//     req_pc/req_target          branch PC and its taken target
//     req_a/req_b                rs1/rs2 operands
//     req_pred_taken             prediction fetch used for this branch
//     lk_pc/lk_taken             fetch-side BHT lookup (combinational)
//     redirect_valid/ready/pc    corrected-PC handshake toward fetch
//     flush                      one-cycle squash pulse
//     resolve_valid/taken        one-cycle retire pulse plus outcome
//     illegal_op                 one-cycle pulse on funct3 010/011
//     br_count/mp_count          statistics counters
//     dbg_state                  current controller state (debug)
// ---------------------------------------------------------------------------
interface branch_resolve_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_funct3;
  logic [31:0]          req_pc;
  logic [31:0]          req_target;
  logic [31:0]          req_a;
  logic [31:0]          req_b;
  logic                 req_pred_taken;
  logic [31:0]          lk_pc;
  logic                 lk_taken;
  logic                 redirect_valid;
  logic                 redirect_ready;
  logic [31:0]          redirect_pc;
  logic                 flush;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 illegal_op;
  logic [CNT_WIDTH-1:0] br_count;
  logic [CNT_WIDTH-1:0] mp_count;
  logic [1:0]           dbg_state;

  modport master (
    output req_valid, req_funct3, req_pc, req_target, req_a, req_b,
           req_pred_taken, lk_pc, redirect_ready,
    input  req_ready, lk_taken, redirect_valid, redirect_pc, flush,
           resolve_valid, resolve_taken, illegal_op, br_count, mp_count,
           dbg_state
  );

  modport slave (
    input  req_valid, req_funct3, req_pc, req_target, req_a, req_b,
           req_pred_taken, lk_pc, redirect_ready,
    output req_ready, lk_taken, redirect_valid, redirect_pc, flush,
           resolve_valid, resolve_taken, illegal_op, br_count, mp_count,
           dbg_state
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//   EX-stage branch resolution controller. Accepts one conditional branch at
//   a time, evaluates it with the branch_cmp comparator, trains a 2-bit
//   bimodal predictor (BHT) and, on a mispredict, raises a redirect to fetch
//   plus a one-cycle flush. Counts resolved branches and mispredicts.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   branch_resolve_ctrl_if.slave (request, lookup, redirect,
//           resolve pulses, statistics, debug state)
//
//   Timing: handshake in cycle N -> EVAL in N+1 -> all result pulses and the
//   first redirect cycle appear in N+2.
// ---------------------------------------------------------------------------

// Combinational RV32I branch comparator. funct3 010/011 are not branches.
module branch_cmp (
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        br_en,
  output logic        illegal
);
  always_comb begin
    br_en   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  br_en = (a == b);
      3'b001:  br_en = (a != b);
      3'b100:  br_en = ($signed(a) <  $signed(b));
      3'b101:  br_en = ($signed(a) >= $signed(b));
      3'b110:  br_en = (a <  b);
      3'b111:  br_en = (a >= b);
      default: illegal = 1'b1;
    endcase
  end
endmodule

module branch_resolve_ctrl #(
  parameter int IDX_BITS  = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_ctrl_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_REDIR = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          target_q, target_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic                 pred_q, pred_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic                 flush_q, flush_d;
  logic                 resolve_valid_q, resolve_valid_d;
  logic                 resolve_taken_q, resolve_taken_d;
  logic                 illegal_op_q, illegal_op_d;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] mp_count_q, mp_count_d;
  logic [1:0]           bht_q [ENTRIES];
  logic [1:0]           bht_d [ENTRIES];

  logic                 br_en;
  logic                 illegal;
  logic                 mispredict;
  logic [1:0]           bht_cur;
  logic [IDX_BITS-1:0]  eval_idx;
  logic [IDX_BITS-1:0]  lk_idx;
  logic                 unused_lk_bits;

  // Comparator works on the registered operands, so it is only meaningful
  // while in EVAL.
  branch_cmp u_cmp (
    .funct3  (funct3_q),
    .a       (a_q),
    .b       (b_q),
    .br_en   (br_en),
    .illegal (illegal)
  );

  assign eval_idx       = pc_q[IDX_BITS+1:2];
  assign lk_idx         = bus.lk_pc[IDX_BITS+1:2];
  assign unused_lk_bits = ^{bus.lk_pc[31:IDX_BITS+2], bus.lk_pc[1:0]};

  // Reads the current flop contents, so a same-cycle update to the same
  // entry is seen only from the next cycle on.
  assign bus.lk_taken = bht_q[lk_idx][1];

  always_comb begin
    state_d          = state_q;
    req_ready_d      = req_ready_q;
    funct3_d         = funct3_q;
    pc_d             = pc_q;
    target_d         = target_q;
    a_d              = a_q;
    b_d              = b_q;
    pred_d           = pred_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    resolve_valid_d  = 1'b0;
    resolve_taken_d  = 1'b0;
    illegal_op_d     = 1'b0;
    br_count_d       = br_count_q;
    mp_count_d       = mp_count_q;
    bht_d            = bht_q;
    bht_cur          = bht_q[eval_idx];
    mispredict       = (br_en != pred_q);

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          funct3_d    = bus.req_funct3;
          pc_d        = bus.req_pc;
          target_d    = bus.req_target;
          a_d         = bus.req_a;
          b_d         = bus.req_b;
          pred_d      = bus.req_pred_taken;
          req_ready_d = 1'b0;
          state_d     = S_EVAL;
        end
      end

      S_EVAL: begin
        resolve_valid_d = 1'b1;
        resolve_taken_d = br_en;
        illegal_op_d    = illegal;
        br_count_d      = br_count_q + CNT_WIDTH'(1);
        // Saturating 2-bit counter; illegal ops never train the predictor.
        if (!illegal) begin
          if (br_en && (bht_cur != 2'b11)) begin
            bht_d[eval_idx] = bht_cur + 2'b01;
          end else if (!br_en && (bht_cur != 2'b00)) begin
            bht_d[eval_idx] = bht_cur - 2'b01;
          end
        end
        if (mispredict) begin
          mp_count_d       = mp_count_q + CNT_WIDTH'(1);
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = br_en ? target_q : (pc_q + 32'd4);
          state_d          = S_REDIR;
        end else begin
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_REDIR: begin
        // redirect_pc_q is untouched here, so it stays stable while stalled.
        if (bus.redirect_ready) begin
          redirect_valid_d = 1'b0;
          req_ready_d      = 1'b1;
          state_d          = S_IDLE;
        end
      end

      default: begin
        redirect_valid_d = 1'b0;
        req_ready_d      = 1'b1;
        state_d          = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      req_ready_q      <= 1'b1;
      funct3_q         <= 3'b000;
      pc_q             <= 32'd0;
      target_q         <= 32'd0;
      a_q              <= 32'd0;
      b_q              <= 32'd0;
      pred_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      resolve_valid_q  <= 1'b0;
      resolve_taken_q  <= 1'b0;
      illegal_op_q     <= 1'b0;
      br_count_q       <= '0;
      mp_count_q       <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      funct3_q         <= funct3_d;
      pc_q             <= pc_d;
      target_q         <= target_d;
      a_q              <= a_d;
      b_q              <= b_d;
      pred_q           <= pred_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      resolve_valid_q  <= resolve_valid_d;
      resolve_taken_q  <= resolve_taken_d;
      illegal_op_q     <= illegal_op_d;
      br_count_q       <= br_count_d;
      mp_count_q       <= mp_count_d;
      bht_q            <= bht_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.resolve_valid  = resolve_valid_q;
  assign bus.resolve_taken  = resolve_taken_q;
  assign bus.illegal_op     = illegal_op_q;
  assign bus.br_count       = br_count_q;
  assign bus.mp_count       = mp_count_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Directed vector table, hand-written reset corner cases and randomized
//   branches, all checked against a behavioural model of the predictor and
//   counters kept in this file.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;
  logic clk;
  logic rst;

  branch_resolve_ctrl_if #(.CNT_WIDTH(32)) bus ();

  branch_resolve_ctrl #(.IDX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int bht_m [64];
  int br_m;
  int mp_m;

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [2:0] f3);
    return (f3 == 3'd2) || (f3 == 3'd3);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    br_m = 0;
    mp_m = 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.req_valid      = 1'b0;
    bus.req_funct3     = 3'd0;
    bus.req_pc         = 32'd0;
    bus.req_target     = 32'd0;
    bus.req_a          = 32'd0;
    bus.req_b          = 32'd0;
    bus.req_pred_taken = 1'b0;
    bus.lk_pc          = 32'd0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
    check({tag, "_flush"}, 32'(bus.flush), 32'd0);
    check({tag, "_resolve_valid"}, 32'(bus.resolve_valid), 32'd0);
    check({tag, "_illegal_op"}, 32'(bus.illegal_op), 32'd0);
    check({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
    check({tag, "_br_count"}, bus.br_count, 32'd0);
    check({tag, "_mp_count"}, bus.mp_count, 32'd0);
  endtask

  task automatic sweep_lk(input string tag);
    for (int i = 0; i < 64; i++) begin
      bus.lk_pc = 32'(i) << 2;
      @(negedge clk);
      check({tag, "_lk_taken"}, 32'(bus.lk_taken), 32'(bht_m[i] >= 2));
    end
  endtask

  // Runs one branch end to end. Entered and left on a negedge with the DUT
  // idle. While a redirect is stalled a stray request is held on the bus;
  // it must not be accepted.
  task automatic run_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic [31:0] a, input logic [31:0] b, input bit pred,
                            input int hold, input bit exp_taken, input bit exp_ill);
    bit          mp;
    logic [31:0] rpc;
    int          idx;
    idx = int'(pc[7:2]);
    mp  = (exp_taken != pred);
    rpc = exp_taken ? tgt : (pc + 32'd4);

    // cycle N
    bus.req_valid      = 1'b1;
    bus.req_funct3     = f3;
    bus.req_pc         = pc;
    bus.req_target     = tgt;
    bus.req_a          = a;
    bus.req_b          = b;
    bus.req_pred_taken = pred;
    bus.lk_pc          = pc;
    check("req_ready_n", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // cycle N+1: BHT still shows the pre-update value
    bus.req_valid = 1'b0;
    check("req_ready_eval", 32'(bus.req_ready), 32'd0);
    check("resolve_early", 32'(bus.resolve_valid), 32'd0);
    check("lk_pre_update", 32'(bus.lk_taken), 32'(bht_m[idx] >= 2));
    br_m++;
    if (mp) mp_m++;
    if (!exp_ill) begin
      if (exp_taken && bht_m[idx] < 3) bht_m[idx]++;
      else if (!exp_taken && bht_m[idx] > 0) bht_m[idx]--;
    end
    @(negedge clk);

    // cycle N+2
    check("resolve_valid", 32'(bus.resolve_valid), 32'd1);
    check("resolve_taken", 32'(bus.resolve_taken), 32'(exp_taken));
    check("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
    check("flush", 32'(bus.flush), 32'(mp));
    check("redirect_valid", 32'(bus.redirect_valid), 32'(mp));
    check("br_count", bus.br_count, 32'(br_m));
    check("mp_count", bus.mp_count, 32'(mp_m));
    check("lk_post_update", 32'(bus.lk_taken), 32'(bht_m[idx] >= 2));

    if (mp) begin
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'hDEAD_0000;
      for (int k = 0; k < hold; k++) begin
        check("hold_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("hold_redirect_pc", bus.redirect_pc, rpc);
        check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        check("hold_flush", 32'(bus.flush), 32'(k == 0));
        @(negedge clk);
      end
      bus.redirect_ready = 1'b1;
      check("xfer_redirect_valid", 32'(bus.redirect_valid), 32'd1);
      check("xfer_redirect_pc", bus.redirect_pc, rpc);
      check("xfer_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      bus.redirect_ready = 1'b0;
      bus.req_valid      = 1'b0;
      check("post_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      check("post_flush", 32'(bus.flush), 32'd0);
      check("post_resolve_valid", 32'(bus.resolve_valid), 32'd0);
      check("post_req_ready", 32'(bus.req_ready), 32'd1);
      check("post_br_count", bus.br_count, 32'(br_m));
    end else begin
      check("req_ready_n2", 32'(bus.req_ready), 32'd1);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] a;
    logic [31:0] b;
    bit          pred;
    int          hold;
    bit          exp_taken;
    bit          exp_ill;
  } vec_t;

  vec_t vecs [20];
  int   n_vecs;

  task automatic add_vec(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] a, input logic [31:0] b, input bit pred,
                         input int hold, input bit exp_taken, input bit exp_ill);
    vecs[n_vecs] = '{f3, pc, tgt, a, b, pred, hold, exp_taken, exp_ill};
    n_vecs++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    bit          pred;
    n_checks = 0;
    n_pass   = 0;
    n_vecs   = 0;

    do_reset();
    check_reset_state("reset");
    sweep_lk("reset");

    //       f3     pc            tgt           a             b             pred hold taken ill
    add_vec(3'd0, 32'h0000_0040, 32'h0000_0080, 32'd5,        32'd5,        1,   0,   1,    0);
    add_vec(3'd4, 32'h0000_0200, 32'h0000_0100, 32'hFFFF_FFFF, 32'd1,       0,   0,   1,    0);
    add_vec(3'd7, 32'hFFFF_FFFC, 32'h0000_0010, 32'hFFFF_FFFF, 32'd1,       1,   0,   1,    0);
    add_vec(3'd6, 32'hFFFF_FFFC, 32'h0000_0010, 32'hFFFF_FFFF, 32'd1,       1,   0,   0,    0);
    add_vec(3'd1, 32'h0000_0300, 32'h0000_1234, 32'd1,        32'd2,        0,   3,   1,    0);
    add_vec(3'd2, 32'h0000_0500, 32'h0000_0900, 32'd7,        32'd7,        0,   0,   0,    1);
    add_vec(3'd3, 32'h0000_0504, 32'h0000_0900, 32'd1,        32'd2,        1,   1,   0,    1);
    add_vec(3'd1, 32'h0000_0600, 32'h0000_0A00, 32'd1,        32'd0,        1,   0,   1,    0);
    add_vec(3'd1, 32'h0000_0600, 32'h0000_0A00, 32'd1,        32'd0,        1,   0,   1,    0);
    add_vec(3'd1, 32'h0000_0600, 32'h0000_0A00, 32'd1,        32'd0,        1,   0,   1,    0);
    add_vec(3'd1, 32'h0000_0600, 32'h0000_0A00, 32'd1,        32'd0,        1,   0,   1,    0);
    add_vec(3'd1, 32'h0000_0600, 32'h0000_0A00, 32'd3,        32'd3,        1,   2,   0,    0);
    add_vec(3'd5, 32'h0000_0700, 32'h0000_0020, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 0, 0,   1,    0);
    add_vec(3'd5, 32'h0000_0704, 32'h0000_0020, 32'h8000_0000, 32'd0,       0,   0,   0,    0);
    add_vec(3'd4, 32'h0000_0708, 32'h0000_0020, 32'd1,        32'h8000_0000, 1,  0,   0,    0);
    add_vec(3'd6, 32'h0000_070C, 32'h0000_0020, 32'd1,        32'h8000_0000, 1,  0,   1,    0);

    for (int i = 0; i < n_vecs; i++) begin
      run_branch(vecs[i].f3, vecs[i].pc, vecs[i].tgt, vecs[i].a, vecs[i].b,
                 vecs[i].pred, vecs[i].hold, vecs[i].exp_taken, vecs[i].exp_ill);
    end

    // Reset while a redirect is pending.
    bus.req_valid      = 1'b1;
    bus.req_funct3     = 3'd0;
    bus.req_pc         = 32'h0000_0800;
    bus.req_target     = 32'h0000_0044;
    bus.req_a          = 32'd1;
    bus.req_b          = 32'd1;
    bus.req_pred_taken = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("redir_before_rst", 32'(bus.redirect_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("rst_in_redir");
    @(negedge clk);
    check("rst_redir_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_redir_valid", 32'(bus.redirect_valid), 32'd0);
    sweep_lk("rst_in_redir");

    // Reset while evaluating: the branch vanishes without any pulse.
    run_branch(3'd0, 32'h0000_0010, 32'h0000_0020, 32'd9, 32'd9, 1, 0, 1, 0);
    bus.req_valid      = 1'b1;
    bus.req_funct3     = 3'd1;
    bus.req_pc         = 32'h0000_0014;
    bus.req_a          = 32'd1;
    bus.req_b          = 32'd2;
    bus.req_pred_taken = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("rst_in_eval");
    bus.lk_pc = 32'h0000_0010;
    @(negedge clk);
    check("rst_eval_lk", 32'(bus.lk_taken), 32'd0);

    // Randomized branches against the model; small index range forces reuse.
    for (int i = 0; i < 300; i++) begin
      f3   = 3'($urandom_range(0, 7));
      pc   = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      a    = $urandom();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom();
      endcase
      pred = 1'($urandom_range(0, 1));
      run_branch(f3, pc, $urandom() & 32'hFFFF_FFFC, a, b, pred,
                 $urandom_range(0, 2), ref_taken(f3, a, b), ref_illegal(f3));
    end
    sweep_lk("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
